// File: rtl/tree_noc_pkg.sv
// Shared types and routing rule for the synchronous tree NoC.
//   flit_t    : {dest, data} flit at the default network widths
//   port_e    : port index of a router node, plus PORT_DROP for misrouted flits
//   route_f() : output port selected for a flit arriving on a given input
package tree_noc_pkg;

  localparam int NOC_ADDR_W = 4;
  localparam int NOC_DATA_W = 8;

  typedef struct packed {
    logic [NOC_ADDR_W-1:0] dest;
    logic [NOC_DATA_W-1:0] data;
  } flit_t;

  typedef enum logic [1:0] {
    PORT_P    = 2'd0,
    PORT_C0   = 2'd1,
    PORT_C1   = 2'd2,
    PORT_DROP = 2'd3
  } port_e;

  function automatic logic [NOC_ADDR_W-1:0] dest(input flit_t f);
    return f.dest;
  endfunction

  function automatic logic [NOC_DATA_W-1:0] data(input flit_t f);
    return f.data;
  endfunction

  // dst is the zero-extended destination address. The root owns every
  // address; any other node owns only the addresses whose bits above
  // LEVEL equal its subtree id.
  function automatic port_e route_f(input logic [31:0] dst, input int level,
                                    input int subtree_id, input int addr_w,
                                    input port_e src);
    logic [31:0] upper;
    logic [31:0] mask;
    logic        in_sub;
    logic        dbit;
    port_e       r;
    mask   = (32'd1 << (addr_w - level - 1)) - 32'd1;
    upper  = (dst >> (level + 1)) & mask;
    in_sub = (level == addr_w - 1) || (upper == $unsigned(subtree_id));
    dbit   = dst[level[4:0]];
    case (src)
      PORT_P:  r = in_sub ? (dbit ? PORT_C1 : PORT_C0) : PORT_DROP;
      // A child flit addressed back into its own half is a U-turn: drop it.
      PORT_C0: r = !in_sub ? PORT_P : (dbit ? PORT_C1 : PORT_DROP);
      PORT_C1: r = !in_sub ? PORT_P : (dbit ? PORT_DROP : PORT_C0);
      default: r = PORT_DROP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty.
//   clk, rst_n  : clock, async active-low reset (pointers/count only)
//   push, wdata : write; caller guarantees !full
//   pop         : read-advance; caller guarantees !empty
//   rdata       : current head, valid while !empty
//   full, empty : occupancy flags derived from the registered count
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/tree_router_sync.sv
// Three-port tree router node (parent p, children c0/c1).
//   CLK, _RESET          : clock, async active-low reset
//   *_in_valid/ready/flit : input handshake into a per-port FIFO
//   *_out_valid/ready/flit: registered output stage per port
//   *_grant               : source of the last load (0 = first-listed source)
//   drop_cnt              : saturating count of misrouted flits
// Output sources: p <- {c0, c1}; c0 <- {c1, p}; c1 <- {c0, p}.
module tree_router_sync
  import tree_noc_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int LEVEL      = 1,
  parameter int SUBTREE_ID = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     _RESET,
  input  logic                     p_in_valid,
  output logic                     p_in_ready,
  input  logic [ADDR_W+DATA_W-1:0] p_in_flit,
  input  logic                     c0_in_valid,
  output logic                     c0_in_ready,
  input  logic [ADDR_W+DATA_W-1:0] c0_in_flit,
  input  logic                     c1_in_valid,
  output logic                     c1_in_ready,
  input  logic [ADDR_W+DATA_W-1:0] c1_in_flit,
  output logic                     p_out_valid,
  input  logic                     p_out_ready,
  output logic [ADDR_W+DATA_W-1:0] p_out_flit,
  output logic                     c0_out_valid,
  input  logic                     c0_out_ready,
  output logic [ADDR_W+DATA_W-1:0] c0_out_flit,
  output logic                     c1_out_valid,
  input  logic                     c1_out_ready,
  output logic [ADDR_W+DATA_W-1:0] c1_out_flit,
  output logic                     p_grant,
  output logic                     c0_grant,
  output logic                     c1_grant,
  output logic [7:0]               drop_cnt
);

  localparam int FW = ADDR_W + DATA_W;

  // Index 0 = p, 1 = c0, 2 = c1 throughout.
  logic [2:0]    in_valid, in_ready, push, pop, drop, head_vld, full, empty;
  logic [2:0]    out_ready, out_valid, grant;
  logic [FW-1:0] in_flit  [3];
  logic [FW-1:0] head     [3];
  logic [FW-1:0] out_flit [3];
  port_e         route    [3];
  logic [2:0]    out_pop  [3];
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] n);
    logic [9:0] s;
    s = {2'b00, a} + {8'b0, n};
    return (s > 10'd255) ? 8'hFF : s[7:0];
  endfunction

  assign in_valid  = {c1_in_valid, c0_in_valid, p_in_valid};
  assign out_ready = {c1_out_ready, c0_out_ready, p_out_ready};
  assign in_flit[0] = p_in_flit;
  assign in_flit[1] = c0_in_flit;
  assign in_flit[2] = c1_in_flit;

  // in_ready depends only on registered occupancy (and reset), never on out_ready.
  assign in_ready = ~full & {3{_RESET}};
  assign push     = in_valid & in_ready;

  // ---- input stage: FIFO + route decode of the head ----
  for (genvar i = 0; i < 3; i++) begin : g_in
    sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (CLK),
      .rst_n (_RESET),
      .push  (push[i]),
      .wdata (in_flit[i]),
      .pop   (pop[i]),
      .rdata (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
    assign head_vld[i] = !empty[i];
    assign route[i]    = route_f(32'(head[i][FW-1 -: ADDR_W]), LEVEL, SUBTREE_ID,
                                 ADDR_W, port_e'(i));
    assign drop[i]     = head_vld[i] && (route[i] == PORT_DROP);
  end

  // ---- output stage: round-robin merge into a registered output ----
  for (genvar o = 0; o < 3; o++) begin : g_out
    localparam int S0 = (o == 0) ? 1 : (o == 1) ? 2 : 1;
    localparam int S1 = (o == 0) ? 2 : 0;

    logic          req0, req1, load, pick1;
    logic          valid_q, valid_d;
    logic          grant_q, grant_d;
    logic          rr_q, rr_d;
    logic [FW-1:0] flit_q, flit_d;

    always_comb begin
      req0    = head_vld[S0] && (route[S0] == port_e'(o));
      req1    = head_vld[S1] && (route[S1] == port_e'(o));
      load    = (!valid_q || out_ready[o]) && (req0 || req1);
      pick1   = req1 && (!req0 || rr_q);
      valid_d = valid_q;
      grant_d = grant_q;
      flit_d  = flit_q;
      rr_d    = rr_q;
      if (load) begin
        valid_d = 1'b1;
        grant_d = pick1;
        flit_d  = pick1 ? head[S1] : head[S0];
        // Only a contested grant moves the pointer, toward the loser.
        if (req0 && req1) rr_d = !pick1;
      end else if (out_ready[o]) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
        valid_q <= 1'b0;
        grant_q <= 1'b0;
        rr_q    <= 1'b0;
        flit_q  <= '0;
      end else begin
        valid_q <= valid_d;
        grant_q <= grant_d;
        rr_q    <= rr_d;
        flit_q  <= flit_d;
      end
    end

    assign out_pop[o]   = !load ? 3'b000 : (pick1 ? (3'b001 << S1) : (3'b001 << S0));
    assign out_valid[o] = valid_q;
    assign grant[o]     = grant_q;
    assign out_flit[o]  = flit_q;
  end

  assign pop = drop | out_pop[0] | out_pop[1] | out_pop[2];

  // ---- drop counter ----
  always_comb begin
    drop_cnt_d = sat_add8(drop_cnt_q, 2'(drop[0]) + 2'(drop[1]) + 2'(drop[2]));
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign p_in_ready   = in_ready[0];
  assign c0_in_ready  = in_ready[1];
  assign c1_in_ready  = in_ready[2];
  assign p_out_valid  = out_valid[0];
  assign c0_out_valid = out_valid[1];
  assign c1_out_valid = out_valid[2];
  assign p_out_flit   = out_flit[0];
  assign c0_out_flit  = out_flit[1];
  assign c1_out_flit  = out_flit[2];
  assign p_grant      = grant[0];
  assign c0_grant     = grant[1];
  assign c1_grant     = grant[2];
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_tree_router_sync.sv
module tb_tree_router_sync;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        p_in_valid, c0_in_valid, c1_in_valid;
  logic        p_in_ready, c0_in_ready, c1_in_ready;
  logic [11:0] p_in_flit, c0_in_flit, c1_in_flit;
  logic        p_out_valid, c0_out_valid, c1_out_valid;
  logic        p_out_ready, c0_out_ready, c1_out_ready;
  logic [11:0] p_out_flit, c0_out_flit, c1_out_flit;
  logic        p_grant, c0_grant, c1_grant;
  logic [7:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  tree_router_sync #(
    .DATA_W(8), .ADDR_W(4), .LEVEL(1), .SUBTREE_ID(1), .FIFO_DEPTH(2)
  ) dut (
    .CLK(CLK), ._RESET(rst_n),
    .p_in_valid(p_in_valid),   .p_in_ready(p_in_ready),   .p_in_flit(p_in_flit),
    .c0_in_valid(c0_in_valid), .c0_in_ready(c0_in_ready), .c0_in_flit(c0_in_flit),
    .c1_in_valid(c1_in_valid), .c1_in_ready(c1_in_ready), .c1_in_flit(c1_in_flit),
    .p_out_valid(p_out_valid),   .p_out_ready(p_out_ready),   .p_out_flit(p_out_flit),
    .c0_out_valid(c0_out_valid), .c0_out_ready(c0_out_ready), .c0_out_flit(c0_out_flit),
    .c1_out_valid(c1_out_valid), .c1_out_ready(c1_out_ready), .c1_out_flit(c1_out_flit),
    .p_grant(p_grant), .c0_grant(c0_grant), .c1_grant(c1_grant),
    .drop_cnt(drop_cnt)
  );

  task automatic idle_inputs();
    p_in_valid = 0; c0_in_valid = 0; c1_in_valid = 0;
    p_in_flit = '0; c0_in_flit = '0; c1_in_flit = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    p_out_ready = 1; c0_out_ready = 1; c1_out_ready = 1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({p_out_valid, c0_out_valid, c1_out_valid} !== 3'b000) begin
      failures++; $display("FAIL reset_out_valid: got %b want 000", {p_out_valid, c0_out_valid, c1_out_valid});
    end
    checks++;
    if ({p_in_ready, c0_in_ready, c1_in_ready} !== 3'b000) begin
      failures++; $display("FAIL reset_in_ready: got %b want 000", {p_in_ready, c0_in_ready, c1_in_ready});
    end
    checks++;
    if ({p_out_flit, c0_out_flit, c1_out_flit, p_grant, c0_grant, c1_grant, drop_cnt} !== 47'd0) begin
      failures++; $display("FAIL reset_flit_grant_cnt: got %h want 0",
                           {p_out_flit, c0_out_flit, c1_out_flit, p_grant, c0_grant, c1_grant, drop_cnt});
    end
    rst_n = 1;
    @(negedge CLK);
    checks++;
    if ({p_in_ready, c0_in_ready, c1_in_ready} !== 3'b111) begin
      failures++; $display("FAIL release_in_ready: got %b want 111", {p_in_ready, c0_in_ready, c1_in_ready});
    end
  endtask

  // c0 -> c1 sideways route, one-cycle latency after acceptance.
  task automatic test_route_sideways();
    @(negedge CLK);
    c0_in_valid = 1; c0_in_flit = 12'h6A5;
    @(negedge CLK);
    idle_inputs();
    checks++;
    if ({p_out_valid, c0_out_valid, c1_out_valid} !== 3'b000) begin
      failures++; $display("FAIL side_early: got %b want 000", {p_out_valid, c0_out_valid, c1_out_valid});
    end
    @(negedge CLK);
    checks++;
    if ({p_out_valid, c0_out_valid, c1_out_valid, c1_out_flit, c1_grant} !== {3'b001, 12'h6A5, 1'b0}) begin
      failures++; $display("FAIL side_c1_out: got v=%b f=%h g=%b want v=001 f=6a5 g=0",
                           {p_out_valid, c0_out_valid, c1_out_valid}, c1_out_flit, c1_grant);
    end
    @(negedge CLK);
    checks++;
    if (c1_out_valid !== 1'b0) begin
      failures++; $display("FAIL side_drain: got %b want 0", c1_out_valid);
    end
  endtask

  // c0 upward to parent and parent downward to c0 on the same edge.
  task automatic test_route_up_down();
    @(negedge CLK);
    c0_in_valid = 1; c0_in_flit = 12'hC11;
    p_in_valid  = 1; p_in_flit  = 12'h522;
    @(negedge CLK);
    idle_inputs();
    @(negedge CLK);
    checks++;
    if ({p_out_valid, p_out_flit, p_grant} !== {1'b1, 12'hC11, 1'b0}) begin
      failures++; $display("FAIL up_p_out: got v=%b f=%h g=%b want v=1 f=c11 g=0", p_out_valid, p_out_flit, p_grant);
    end
    checks++;
    if ({c0_out_valid, c0_out_flit, c0_grant, c1_out_valid} !== {1'b1, 12'h522, 1'b1, 1'b0}) begin
      failures++; $display("FAIL down_c0_out: got v=%b f=%h g=%b c1v=%b want v=1 f=522 g=1 c1v=0",
                           c0_out_valid, c0_out_flit, c0_grant, c1_out_valid);
    end
    @(negedge CLK);
  endtask

  task automatic test_drop();
    logic [2:0] seen_valid;
    @(negedge CLK);
    c0_in_valid = 1; c0_in_flit = 12'h533;
    p_in_valid  = 1; p_in_flit  = 12'h944;
    @(negedge CLK);
    idle_inputs();
    @(negedge CLK);
    checks++;
    if (drop_cnt !== 8'd2) begin
      failures++; $display("FAIL drop_two: got %0d want 2", drop_cnt);
    end
    checks++;
    if ({p_out_valid, c0_out_valid, c1_out_valid} !== 3'b000) begin
      failures++; $display("FAIL drop_no_out: got %b want 000", {p_out_valid, c0_out_valid, c1_out_valid});
    end
    // Continuous stream of misrouted parent flits, one drop per cycle.
    seen_valid = 3'b000;
    p_in_valid = 1; p_in_flit = 12'h9AB;
    for (int k = 1; k <= 310; k++) begin
      @(negedge CLK);
      seen_valid |= {p_out_valid, c0_out_valid, c1_out_valid};
      if (k == 100) begin
        checks++;
        if (drop_cnt !== 8'd101) begin
          failures++; $display("FAIL drop_mid: got %0d want 101", drop_cnt);
        end
      end
    end
    idle_inputs();
    repeat (3) @(negedge CLK);
    checks++;
    if (drop_cnt !== 8'd255) begin
      failures++; $display("FAIL drop_saturate: got %0d want 255", drop_cnt);
    end
    checks++;
    if (seen_valid !== 3'b000) begin
      failures++; $display("FAIL drop_stream_no_out: got %b want 000", seen_valid);
    end
  endtask

  // c0 and c1 contend for p_out every cycle; grants must alternate.
  task automatic test_rr_alternate();
    int n0 = 0, n1 = 0, nout = 0;
    logic acc0, acc1;
    logic [11:0] exp_f;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge CLK);
      if (p_out_valid && nout < 8) begin
        exp_f = (nout % 2 == 1) ? {4'hF, 8'h80 + 8'(nout / 2)} : {4'hF, 8'(nout / 2)};
        checks++;
        if ({p_grant, p_out_flit} !== {1'(nout % 2), exp_f}) begin
          failures++; $display("FAIL rr_out%0d: got g=%b f=%h want g=%0d f=%h",
                               nout, p_grant, p_out_flit, nout % 2, exp_f);
        end
        nout++;
      end
      c0_in_valid = 1; c0_in_flit = {4'hF, 8'(n0)};
      c1_in_valid = 1; c1_in_flit = {4'hF, 8'h80 + 8'(n1)};
      acc0 = c0_in_ready; acc1 = c1_in_ready;
      @(posedge CLK);
      if (acc0) n0++;
      if (acc1) n1++;
    end
    @(negedge CLK);
    idle_inputs();
    checks++;
    if (nout !== 8) begin
      failures++; $display("FAIL rr_count: got %0d want 8", nout);
    end
    repeat (8) @(negedge CLK);
  endtask

  // Back-pressure with FIFO_DEPTH=2, then release: order kept, no loss or duplication.
  task automatic test_fifo_full();
    int i = 0, nout = 0;
    logic acc;
    p_out_ready = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge CLK);
      c0_in_valid = (i < 4); c0_in_flit = {4'hF, 8'hF0 + 8'(i)};
      acc = c0_in_valid && c0_in_ready;
      @(posedge CLK);
      if (acc) i++;
    end
    @(negedge CLK);
    checks++;
    if (i !== 3 || c0_in_ready !== 1'b0) begin
      failures++; $display("FAIL full_accept: got n=%0d rdy=%b want n=3 rdy=0", i, c0_in_ready);
    end
    checks++;
    if ({p_out_valid, p_out_flit} !== {1'b1, 12'hFF0}) begin
      failures++; $display("FAIL full_hold: got v=%b f=%h want v=1 f=ff0", p_out_valid, p_out_flit);
    end
    p_out_ready = 1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc != 0) @(negedge CLK);
      if (p_out_valid) begin
        checks++;
        if (nout >= 4 || p_out_flit !== {4'hF, 8'hF0 + 8'(nout)}) begin
          failures++; $display("FAIL full_order%0d: got %h want %h", nout, p_out_flit, {4'hF, 8'hF0 + 8'(nout)});
        end
        nout++;
      end
      c0_in_valid = (i < 4); c0_in_flit = {4'hF, 8'hF0 + 8'(i)};
      acc = c0_in_valid && c0_in_ready;
      @(posedge CLK);
      if (acc) i++;
    end
    @(negedge CLK);
    idle_inputs();
    checks++;
    if (nout !== 4 || i !== 4) begin
      failures++; $display("FAIL full_total: got out=%0d in=%0d want 4 4", nout, i);
    end
  endtask

  task automatic test_reset_midstream();
    p_out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      c0_in_valid = 1; c0_in_flit = {4'hF, 8'hE0 + 8'(k)};
    end
    @(negedge CLK);
    rst_n = 0;
    #1;
    checks++;
    if ({p_out_valid, c0_out_valid, c1_out_valid, p_in_ready, c0_in_ready, c1_in_ready} !== 6'b0) begin
      failures++; $display("FAIL midrst_immediate: got %b want 000000",
                           {p_out_valid, c0_out_valid, c1_out_valid, p_in_ready, c0_in_ready, c1_in_ready});
    end
    checks++;
    if (drop_cnt !== 8'd0) begin
      failures++; $display("FAIL midrst_drop_cnt: got %0d want 0", drop_cnt);
    end
    idle_inputs();
    @(negedge CLK);
    rst_n = 1;
    p_out_ready = 1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({p_out_valid, c0_out_valid, c1_out_valid, p_in_ready, c0_in_ready, c1_in_ready} !== 6'b000111) begin
      failures++; $display("FAIL midrst_empty: got %b want 000111",
                           {p_out_valid, c0_out_valid, c1_out_valid, p_in_ready, c0_in_ready, c1_in_ready});
    end
    c0_in_valid = 1; c0_in_flit = 12'h65A;
    @(negedge CLK);
    idle_inputs();
    @(negedge CLK);
    checks++;
    if ({p_out_valid, c0_out_valid, c1_out_valid, c1_out_flit, c1_grant} !== {3'b001, 12'h65A, 1'b0}) begin
      failures++; $display("FAIL midrst_first_flit: got v=%b f=%h g=%b want v=001 f=65a g=0",
                           {p_out_valid, c0_out_valid, c1_out_valid}, c1_out_flit, c1_grant);
    end
  endtask

  initial begin
    test_reset();
    test_route_sideways();
    test_route_up_down();
    test_drop();
    test_rr_alternate();
    test_fifo_full();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
